// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory/writeback stage.
//   - Default datapath and register-index widths
//   - Memory-op codes, load/store width codes, FSM state type
//   - access_legal(): decides whether a load/store can be issued
package mem_wb_stage_pkg;

    localparam int REG_LEN_DEF = 32;
    localparam int RF_ADDR_DEF = 5;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'b00,
        MEM_OP_LOAD  = 2'b01,
        MEM_OP_STORE = 2'b10,
        MEM_OP_RSVD  = 2'b11
    } mem_op_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_WB   = 2'b11
    } state_e;

    // Legal width code and naturally aligned address. Stores have no
    // unsigned variants, so BU/HU are illegal for them.
    function automatic logic access_legal(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo,
                                          input logic       is_store);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !is_store;
            F3_H:    ok = !addr_lo[0];
            F3_HU:   ok = !is_store && !addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// load_ext: combinational load-data extraction.
//   rdata   : full memory word
//   addr_lo : byte offset of the access
//   funct3  : width/sign code (B, H, W, BU, HU)
//   ext     : selected lane, sign- or zero-extended to the datapath width
module load_ext
    import mem_wb_stage_pkg::*;
#(
    parameter int REG_LEN = REG_LEN_DEF
) (
    input  logic [REG_LEN-1:0] rdata,
    input  logic [1:0]         addr_lo,
    input  logic [2:0]         funct3,
    output logic [REG_LEN-1:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'b00:   byte_sel = rdata[7:0];
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    ext = {{(REG_LEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   ext = {{(REG_LEN-8){1'b0}}, byte_sel};
            F3_H:    ext = {{(REG_LEN-16){half_sel[15]}}, half_sel};
            F3_HU:   ext = {{(REG_LEN-16){1'b0}}, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: stage after the ALU. ALU results go straight to the
// register file; loads/stores use alu_out as the data-memory address.
//   clk, rst_n           : clock, synchronous active-low reset
//   ex_valid / ex_ready  : handshake with execute
//   alu_out, ex_rs2_data, ex_rd, ex_reg_we, ex_mem_op, ex_funct3 : op from execute
//   dmem_req/we/addr/be/wdata, dmem_gnt/rvalid/rdata : data-memory port
//   rf_we, rf_rd, rf_wdata : register-file write port (one-cycle strobe)
//   mem_err              : one-cycle pulse for misaligned/illegal access
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int REG_LEN = REG_LEN_DEF,
    parameter int RF_ADDR = RF_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [REG_LEN-1:0] alu_out,
    input  logic [REG_LEN-1:0] ex_rs2_data,
    input  logic [RF_ADDR-1:0] ex_rd,
    input  logic               ex_reg_we,
    input  logic [1:0]         ex_mem_op,
    input  logic [2:0]         ex_funct3,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [REG_LEN-1:0] dmem_addr,
    output logic [3:0]         dmem_be,
    output logic [REG_LEN-1:0] dmem_wdata,
    input  logic               dmem_gnt,
    input  logic               dmem_rvalid,
    input  logic [REG_LEN-1:0] dmem_rdata,
    output logic               rf_we,
    output logic [RF_ADDR-1:0] rf_rd,
    output logic [REG_LEN-1:0] rf_wdata,
    output logic               mem_err
);

    state_e             state_reg, state_next;
    logic [1:0]         addr_lo_reg, addr_lo_next;
    logic [2:0]         funct3_reg, funct3_next;
    logic [RF_ADDR-1:0] pend_rd_reg, pend_rd_next;
    logic               pend_we_reg, pend_we_next;
    logic               dmem_req_reg, dmem_req_next;
    logic               dmem_we_reg, dmem_we_next;
    logic [REG_LEN-1:0] dmem_addr_reg, dmem_addr_next;
    logic [3:0]         dmem_be_reg, dmem_be_next;
    logic [REG_LEN-1:0] dmem_wdata_reg, dmem_wdata_next;
    logic               rf_we_reg, rf_we_next;
    logic [RF_ADDR-1:0] rf_rd_reg, rf_rd_next;
    logic [REG_LEN-1:0] rf_wdata_reg, rf_wdata_next;
    logic               mem_err_reg, mem_err_next;

    logic               accept;
    mem_op_e            mem_op;
    logic               is_load, is_store, legal;
    logic [3:0]         al_be;
    logic [REG_LEN-1:0] al_wdata;
    logic [REG_LEN-1:0] load_val;

    load_ext #(.REG_LEN(REG_LEN)) u_load_ext (
        .rdata   (dmem_rdata),
        .addr_lo (addr_lo_reg),
        .funct3  (funct3_reg),
        .ext     (load_val)
    );

    assign ex_ready = (state_reg == ST_IDLE) || (state_reg == ST_WB);
    assign accept   = ex_valid && ex_ready;
    assign mem_op   = mem_op_e'(ex_mem_op);
    assign is_load  = (mem_op == MEM_OP_LOAD);
    assign is_store = (mem_op == MEM_OP_STORE);
    assign legal    = access_legal(ex_funct3, alu_out[1:0], is_store);

    // Byte enables and lane-replicated data depend only on the access
    // size (funct3[1:0]); the sign bit does not matter here.
    always_comb begin
        case (ex_funct3[1:0])
            2'b00: begin
                al_be    = 4'b0001 << alu_out[1:0];
                al_wdata = {(REG_LEN/8){ex_rs2_data[7:0]}};
            end
            2'b01: begin
                al_be    = alu_out[1] ? 4'b1100 : 4'b0011;
                al_wdata = {(REG_LEN/16){ex_rs2_data[15:0]}};
            end
            default: begin
                al_be    = 4'b1111;
                al_wdata = ex_rs2_data;
            end
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        addr_lo_next    = addr_lo_reg;
        funct3_next     = funct3_reg;
        pend_rd_next    = pend_rd_reg;
        pend_we_next    = pend_we_reg;
        dmem_req_next   = dmem_req_reg;
        dmem_we_next    = dmem_we_reg;
        dmem_addr_next  = dmem_addr_reg;
        dmem_be_next    = dmem_be_reg;
        dmem_wdata_next = dmem_wdata_reg;
        rf_we_next      = 1'b0;
        rf_rd_next      = rf_rd_reg;
        rf_wdata_next   = rf_wdata_reg;
        mem_err_next    = 1'b0;

        case (state_reg)
            ST_IDLE, ST_WB: begin
                state_next = ST_IDLE;
                if (accept) begin
                    if (is_load || is_store) begin
                        if (!legal) begin
                            mem_err_next = 1'b1;
                        end else begin
                            state_next      = ST_REQ;
                            dmem_req_next   = 1'b1;
                            dmem_we_next    = is_store;
                            dmem_addr_next  = {alu_out[REG_LEN-1:2], 2'b00};
                            dmem_be_next    = al_be;
                            dmem_wdata_next = al_wdata;
                            addr_lo_next    = alu_out[1:0];
                            funct3_next     = ex_funct3;
                            pend_rd_next    = ex_rd;
                            pend_we_next    = ex_reg_we;
                        end
                    end else begin
                        // Plain ALU op, including the reserved mem_op code.
                        state_next    = ST_WB;
                        rf_we_next    = ex_reg_we && (ex_rd != '0);
                        rf_rd_next    = ex_rd;
                        rf_wdata_next = alu_out;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    dmem_req_next = 1'b0;
                    dmem_we_next  = 1'b0;
                    if (dmem_we_reg) begin
                        state_next = ST_IDLE;
                    end else if (dmem_rvalid) begin
                        state_next    = ST_WB;
                        rf_we_next    = pend_we_reg && (pend_rd_reg != '0);
                        rf_rd_next    = pend_rd_reg;
                        rf_wdata_next = load_val;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    state_next    = ST_WB;
                    rf_we_next    = pend_we_reg && (pend_rd_reg != '0);
                    rf_rd_next    = pend_rd_reg;
                    rf_wdata_next = load_val;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            addr_lo_reg    <= '0;
            funct3_reg     <= '0;
            pend_rd_reg    <= '0;
            pend_we_reg    <= 1'b0;
            dmem_req_reg   <= 1'b0;
            dmem_we_reg    <= 1'b0;
            dmem_addr_reg  <= '0;
            dmem_be_reg    <= '0;
            dmem_wdata_reg <= '0;
            rf_we_reg      <= 1'b0;
            rf_rd_reg      <= '0;
            rf_wdata_reg   <= '0;
            mem_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_lo_reg    <= addr_lo_next;
            funct3_reg     <= funct3_next;
            pend_rd_reg    <= pend_rd_next;
            pend_we_reg    <= pend_we_next;
            dmem_req_reg   <= dmem_req_next;
            dmem_we_reg    <= dmem_we_next;
            dmem_addr_reg  <= dmem_addr_next;
            dmem_be_reg    <= dmem_be_next;
            dmem_wdata_reg <= dmem_wdata_next;
            rf_we_reg      <= rf_we_next;
            rf_rd_reg      <= rf_rd_next;
            rf_wdata_reg   <= rf_wdata_next;
            mem_err_reg    <= mem_err_next;
        end
    end

    assign dmem_req   = dmem_req_reg;
    assign dmem_we    = dmem_we_reg;
    assign dmem_addr  = dmem_addr_reg;
    assign dmem_be    = dmem_be_reg;
    assign dmem_wdata = dmem_wdata_reg;
    assign rf_we      = rf_we_reg;
    assign rf_rd      = rf_rd_reg;
    assign rf_wdata   = rf_wdata_reg;
    assign mem_err    = mem_err_reg;

endmodule
